mcp9808_temp_decoder: RTL and testbench

//  Downstream consumer of the MCP9808 I2C interface READ_TEMP transfer.
//  - Assembles the two received bytes of the Ambient Temperature register.
//  - Splits off the alert flags and applies the configured resolution mask.
//  - Converts the 13-bit two's-complement value to sign + 7-digit BCD (xxx.xxxx degC) for the display path.
//  - A 1-deep pending buffer decouples byte reception from the sequential conversion.

---
 rtl/mcp9808_temp_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_mcp9808_temp_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp9808_temp_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mcp9808_temp_decoder
// Description : Assembles MCP9808 Ambient Temperature register bytes, splits
//               off alert flags, applies resolution masking and converts the
//               13-bit two's-complement value to sign + 7-digit BCD
//               (xxx.xxxx degC). A one-word pending slot decouples byte
//               reception from the sequential conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module mcp9808_temp_decoder #(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit APPLY_RES = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_first,
  input  logic [1:0]  res_i,
  input  logic        ovr_clr,
  output logic [12:0] temp_raw,
  output logic [2:0]  flags,
  output logic        sign,
  output logic [27:0] bcd,
  output logic        temp_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [0:0] {A_IDLE = 1'b0, A_SECOND = 1'b1} asm_state_t;
  typedef enum logic [1:0] {C_IDLE = 2'd0, C_LOAD = 2'd1, C_SHIFT = 2'd2, C_DONE = 2'd3} cv_state_t;

  localparam logic [4:0] c_LAST_ITER = 5'd21;

  asm_state_t  r_a_state, w_a_next;
  cv_state_t   r_c_state, w_c_next;
  logic [7:0]  r_first_byte;
  logic        w_word_done;
  logic [15:0] w_word;
  logic        r_slot_full;
  logic [15:0] r_slot_word;
  logic        w_consume;
  logic [15:0] r_cv_word;
  logic [12:0] w_t_masked;
  logic [12:0] w_mag;
  logic [21:0] w_mag22;
  logic [21:0] w_prod;
  logic [12:0] r_t;
  logic [2:0]  r_cv_flags;
  logic [21:0] r_bin;
  logic [27:0] r_bcd_sh;
  logic [27:0] w_bcd_adj;
  logic [27:0] w_bcd_next;
  logic [4:0]  r_iter;
  logic        w_last_iter;
  logic        r_overrun;
  logic [12:0] r_temp_raw;
  logic [2:0]  r_flags;
  logic        r_sign;
  logic [27:0] r_bcd;
  logic        r_temp_valid;

  // Byte order of the assembled register word.
  assign w_word = MSB_FIRST ? {r_first_byte, rx_data} : {rx_data, r_first_byte};

  // Assembler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_a_state <= A_IDLE;
    else     r_a_state <= w_a_next;
  end

  // Assembler next state; a new first byte always restarts the pair.
  always_comb begin
    w_a_next    = r_a_state;
    w_word_done = 1'b0;
    case (r_a_state)
      A_IDLE:   if (rx_valid && rx_first) w_a_next = A_SECOND;
      A_SECOND: begin
        if (rx_valid && !rx_first) begin
          w_word_done = 1'b1;
          w_a_next    = A_IDLE;
        end
      end
      default:  w_a_next = A_IDLE;
    endcase
  end

  // Hold the most recent first byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_first_byte <= 8'd0;
    else if (rx_valid && rx_first) r_first_byte <= rx_data;
  end

  // The converter takes the slot when idle or when finishing, so back-to-back
  // words convert at the minimum 24-cycle spacing.
  assign w_consume = r_slot_full && (r_c_state == C_IDLE || r_c_state == C_DONE);

  // Pending slot: a write on the consume edge leaves it full with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_full <= 1'b0;
      r_slot_word <= 16'd0;
    end else if (w_word_done) begin
      r_slot_full <= 1'b1;
      r_slot_word <= w_word;
    end else if (w_consume) begin
      r_slot_full <= 1'b0;
    end
  end

  // Sticky overrun: only a word lost without being consumed counts; set wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_overrun <= 1'b0;
    else if (w_word_done && r_slot_full && !w_consume) r_overrun <= 1'b1;
    else if (ovr_clr)                             r_overrun <= 1'b0;
  end

  // Converter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_c_state <= C_IDLE;
    else     r_c_state <= w_c_next;
  end

  assign w_last_iter = (r_c_state == C_SHIFT) && (r_iter == c_LAST_ITER);

  // Converter next state.
  always_comb begin
    w_c_next = r_c_state;
    case (r_c_state)
      C_IDLE:  if (r_slot_full) w_c_next = C_LOAD;
      C_LOAD:  w_c_next = C_SHIFT;
      C_SHIFT: if (w_last_iter) w_c_next = C_DONE;
      C_DONE:  w_c_next = r_slot_full ? C_LOAD : C_IDLE;
      default: w_c_next = C_IDLE;
    endcase
  end

  // Resolution mask; clearing LSBs of a two's-complement value truncates toward -inf.
  always_comb begin
    w_t_masked = r_cv_word[12:0];
    if (APPLY_RES) begin
      case (res_i)
        2'd0:    w_t_masked[2:0] = 3'd0;
        2'd1:    w_t_masked[1:0] = 2'd0;
        2'd2:    w_t_masked[0]   = 1'b0;
        default: w_t_masked = r_cv_word[12:0];
      endcase
    end
  end

  // Magnitude (-4096 maps to 4096, still fits 13 unsigned bits) times 625.
  assign w_mag   = w_t_masked[12] ? (~w_t_masked + 13'd1) : w_t_masked;
  assign w_mag22 = {9'd0, w_mag};
  assign w_prod  = (w_mag22 << 9) + (w_mag22 << 6) + (w_mag22 << 5) + (w_mag22 << 4) + w_mag22;

  // Double-dabble add-3 correction per BCD digit.
  for (genvar gi = 0; gi < 7; gi++) begin : g_dabble
    assign w_bcd_adj[4*gi +: 4] = (r_bcd_sh[4*gi +: 4] >= 4'd5) ?
                                  (r_bcd_sh[4*gi +: 4] + 4'd3) : r_bcd_sh[4*gi +: 4];
  end
  assign w_bcd_next = {w_bcd_adj[26:0], r_bin[21]};

  // Conversion datapath: latch word, load product, then one dabble step per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cv_word  <= 16'd0;
      r_t        <= 13'd0;
      r_cv_flags <= 3'd0;
      r_bin      <= 22'd0;
      r_bcd_sh   <= 28'd0;
      r_iter     <= 5'd0;
    end else begin
      if (w_consume) r_cv_word <= r_slot_word;
      case (r_c_state)
        C_LOAD: begin
          r_t        <= w_t_masked;
          r_cv_flags <= r_cv_word[15:13];
          r_bin      <= w_prod;
          r_bcd_sh   <= 28'd0;
          r_iter     <= 5'd0;
        end
        C_SHIFT: begin
          r_bin    <= {r_bin[20:0], 1'b0};
          r_bcd_sh <= w_bcd_next;
          r_iter   <= r_iter + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers update together with the final dabble step; valid pulses once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_temp_raw   <= 13'd0;
      r_flags      <= 3'd0;
      r_sign       <= 1'b0;
      r_bcd        <= 28'd0;
      r_temp_valid <= 1'b0;
    end else begin
      r_temp_valid <= w_last_iter;
      if (w_last_iter) begin
        r_temp_raw <= r_t;
        r_flags    <= r_cv_flags;
        r_sign     <= r_t[12];
        r_bcd      <= w_bcd_next;
      end
    end
  end

  assign temp_raw   = r_temp_raw;
  assign flags      = r_flags;
  assign sign       = r_sign;
  assign bcd        = r_bcd;
  assign temp_valid = r_temp_valid;
  assign overrun    = r_overrun;
  assign busy       = r_slot_full | (r_c_state != C_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mcp9808_temp_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcp9808_temp_decoder
// Description : Self-checking bench: directed frames with literal expectations
//               plus randomized byte traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcp9808_temp_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_first = 1'b0;
  logic [1:0]  res_i = 2'd3;
  logic        ovr_clr = 1'b0;
  logic [12:0] temp_raw;
  logic [2:0]  flags;
  logic        sign;
  logic [27:0] bcd;
  logic        temp_valid;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  mcp9808_temp_decoder #(.MSB_FIRST(1'b1), .APPLY_RES(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .res_i(res_i), .ovr_clr(ovr_clr), .temp_raw(temp_raw), .flags(flags), .sign(sign),
    .bcd(bcd), .temp_valid(temp_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion from the datasheet arithmetic.
  function automatic void calc(input logic [15:0] w, input int res,
                               output logic [12:0] raw, output logic [2:0] fl,
                               output logic sg, output logic [27:0] b);
    int t, step, m, mag, x;
    t = int'(w[12:0]);
    if (t >= 4096) t = t - 8192;
    step = 8 >> res;
    m = t - (((t % step) + step) % step);
    raw = m[12:0];
    fl  = w[15:13];
    sg  = (m < 0);
    mag = sg ? -m : m;
    x   = mag * 625;
    b   = 28'd0;
    for (int i = 0; i < 7; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
  endfunction

  // Behavioural model state (edge-counted, transaction level).
  int          m_n = 0;
  int          m_next_free = 0;
  int          m_start = 0;
  int          m_res = 3;
  bit          m_active = 0;
  bit          m_have_first = 0;
  logic [7:0]  m_first = 8'd0;
  bit          m_slot_full = 0;
  logic [15:0] m_slot = 16'd0;
  logic [15:0] m_cw = 16'd0;
  bit          m_ovr = 0;
  bit          m_valid = 0;
  bit          m_busy = 0;
  logic [12:0] m_raw = 13'd0;
  logic [2:0]  m_fl = 3'd0;
  logic        m_sg = 1'b0;
  logic [27:0] m_bcd = 28'd0;

  always @(posedge clk or posedge rst) begin
    bit          done, take;
    logic [15:0] w;
    if (rst) begin
      m_next_free = 0; m_active = 0; m_have_first = 0; m_slot_full = 0;
      m_ovr = 0; m_valid = 0; m_busy = 0;
      m_raw = 13'd0; m_fl = 3'd0; m_sg = 1'b0; m_bcd = 28'd0;
    end else begin
      m_n++;
      m_valid = 0;
      if (m_active && m_n == m_start + 1) m_res = int'(res_i);
      if (m_active && m_n == m_start + 23) begin
        calc(m_cw, m_res, m_raw, m_fl, m_sg, m_bcd);
        m_valid = 1;
      end
      take = m_slot_full && (m_n >= m_next_free);
      if (take) begin
        m_cw = m_slot; m_start = m_n; m_active = 1; m_next_free = m_n + 24;
      end
      done = 0; w = 16'd0;
      if (rx_valid) begin
        if (rx_first) begin
          m_have_first = 1; m_first = rx_data;
        end else if (m_have_first) begin
          done = 1; w = {m_first, rx_data}; m_have_first = 0;
        end
      end
      if (done && m_slot_full && !take) m_ovr = 1;
      else if (ovr_clr)                 m_ovr = 0;
      if (done) begin
        m_slot_full = 1; m_slot = w;
      end else if (take) begin
        m_slot_full = 0;
      end
      m_busy = m_slot_full || (m_active && m_n < m_start + 24);
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    check("m_temp_valid", temp_valid, m_valid);
    check("m_busy", busy, m_busy);
    check("m_overrun", overrun, m_ovr);
    check("m_temp_raw", temp_raw, m_raw);
    check("m_flags", flags, m_fl);
    check("m_sign", sign, m_sg);
    check("m_bcd", bcd, m_bcd);
  end

  task automatic sync();
    @(posedge clk); #2;
  endtask

  // Two-byte frame; returns two time units after the completing edge.
  task automatic send(input logic [7:0] b0, input logic [7:0] b1);
    rx_valid = 1'b1; rx_first = 1'b1; rx_data = b0;
    sync();
    rx_first = 1'b0; rx_data = b1;
    sync();
    rx_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (temp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_results(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (temp_valid) cnt++;
    end
  endtask

  initial begin
    int lat, cnt;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", temp_valid, 1'b0);
    check("reset_bcd", bcd, 28'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_overrun", overrun, 1'b0);

    // 25.25 degC at full resolution
    sync();
    send(8'h01, 8'h94);
    wait_result(lat);
    check("t1_latency", lat, 24);
    check("t1_raw", temp_raw, 13'h0194);
    check("t1_sign", sign, 1'b0);
    check("t1_bcd", bcd, 28'h0252500);
    check("t1_flags", flags, 3'b000);
    @(negedge clk);
    check("t1_pulse_width", temp_valid, 1'b0);

    // Negative values
    sync();
    send(8'h1F, 8'hF0);
    wait_result(lat);
    check("t2a_sign", sign, 1'b1);
    check("t2a_bcd", bcd, 28'h0010000);
    sync();
    send(8'h10, 8'h00);
    wait_result(lat);
    check("t2b_sign", sign, 1'b1);
    check("t2b_bcd", bcd, 28'h2560000);
    check("t2b_raw", temp_raw, 13'h1000);

    // Flags and coarse resolution
    sync();
    send(8'hE1, 8'h94);
    wait_result(lat);
    check("t3a_flags", flags, 3'b111);
    check("t3a_bcd", bcd, 28'h0252500);
    sync();
    res_i = 2'd0;
    send(8'h01, 8'h97);
    wait_result(lat);
    check("t3b_raw", temp_raw, 13'h0190);
    check("t3b_bcd", bcd, 28'h0250000);
    sync();
    send(8'h1F, 8'hFF);
    wait_result(lat);
    check("t3c_bcd", bcd, 28'h0005000);
    check("t3c_sign", sign, 1'b1);
    res_i = 2'd3;

    // Restart on repeated first byte; lone second byte ignored
    sync();
    rx_valid = 1'b1; rx_first = 1'b1; rx_data = 8'h01;
    sync();
    rx_data = 8'h02;
    sync();
    rx_first = 1'b0; rx_data = 8'h00;
    sync();
    rx_valid = 1'b0;
    wait_result(lat);
    check("t4_bcd", bcd, 28'h0320000);
    count_results(40, cnt);
    check("t4_single", cnt, 0);
    sync();
    rx_valid = 1'b1; rx_first = 1'b0; rx_data = 8'h55;
    sync();
    rx_valid = 1'b0;
    count_results(40, cnt);
    check("t4_lone", cnt, 0);

    // Overrun: three words two cycles apart
    sync();
    send(8'h01, 8'h94);
    send(8'h1F, 8'hF0);
    send(8'h10, 8'h00);
    wait_result(lat);
    check("t5_first_bcd", bcd, 28'h0252500);
    check("t5_overrun", overrun, 1'b1);
    check("t5_busy", busy, 1'b1);
    wait_result(lat);
    check("t5_second_bcd", bcd, 28'h2560000);
    check("t5_overrun_held", overrun, 1'b1);
    sync();
    ovr_clr = 1'b1;
    sync();
    ovr_clr = 1'b0;
    @(negedge clk);
    check("t5_overrun_clr", overrun, 1'b0);

    // Reset in the middle of the shift phase
    sync();
    send(8'h02, 8'h58);
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_raw", temp_raw, 13'd0);
    check("t6_bcd", bcd, 28'd0);
    check("t6_busy", busy, 1'b0);
    check("t6_valid", temp_valid, 1'b0);
    sync();
    rst = 1'b0;
    count_results(40, cnt);
    check("t6_no_result", cnt, 0);
    sync();
    send(8'h02, 8'h58);
    wait_result(lat);
    check("t6_latency", lat, 24);
    check("t6_bcd_after", bcd, 28'h0375000);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      sync();
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_first = $urandom_range(0, 1) == 1;
      rx_data  = 8'($urandom);
      if ($urandom_range(0, 49) == 0) res_i = 2'($urandom);
      ovr_clr  = ($urandom_range(0, 39) == 0);
    end
    sync();
    rx_valid = 1'b0;
    ovr_clr  = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
